// File: rtl/sample_stream_tx.sv
// rtl/sample_stream_tx.sv - FIFO-buffered parallel-to-serial sample feeder, MSB first
module sample_stream_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_en,
  input  logic [DATA_WIDTH-1:0]              iv_din,
  input  logic                               i_din_valid,
  output logic                               o_ready,
  output logic                               o_dout,
  output logic                               o_dout_valid,
  input  logic                               i_ready,
  output logic                               o_frame_start,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    ov_fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]         bitcnt_q, bitcnt_d;
  logic                  push, pop, xfer, fifo_nonempty;

  // Full blocks input even when a pop happens the same cycle: no pass-through path.
  assign o_ready       = i_en & i_rst_n & (count_q != COUNT_FULL);
  assign push          = i_din_valid & o_ready;
  assign fifo_nonempty = (count_q != '0);
  assign o_dout_valid  = i_en & (state_q == SHIFT);
  assign xfer          = o_dout_valid & i_ready;
  assign o_dout        = shreg_q[DATA_WIDTH-1];
  assign o_frame_start = (state_q == SHIFT) && (bitcnt_q == BIT_LAST);
  assign ov_fifo_count = count_q;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    pop      = 1'b0;
    if (i_en) begin
      case (state_q)
        IDLE: begin
          if (fifo_nonempty) begin
            pop      = 1'b1;
            shreg_d  = mem[rd_ptr_q];
            bitcnt_d = BIT_LAST;
            state_d  = SHIFT;
          end
        end
        SHIFT: begin
          if (xfer) begin
            if (bitcnt_q != '0) begin
              shreg_d  = shreg_q << 1;
              bitcnt_d = bitcnt_q - BW'(1);
            end else if (fifo_nonempty) begin
              // Reload straight from the FIFO so consecutive words have no idle bit.
              pop      = 1'b1;
              shreg_d  = mem[rd_ptr_q];
              bitcnt_d = BIT_LAST;
            end else begin
              state_d  = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= iv_din;
  end

endmodule

// File: tb/tb_sample_stream_tx.sv
// tb/tb_sample_stream_tx.sv - self-checking bench for sample_stream_tx
module tb_sample_stream_tx;

  localparam int DW    = 24;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          ready_out;
  logic          dout;
  logic          dout_valid;
  logic          ready_in;
  logic          frame_start;
  logic [3:0]    fifo_count;

  sample_stream_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_en          (en),
    .iv_din        (din),
    .i_din_valid   (din_valid),
    .o_ready       (ready_out),
    .o_dout        (dout),
    .o_dout_valid  (dout_valid),
    .i_ready       (ready_in),
    .o_frame_start (frame_start),
    .ov_fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q [$];
  int            bit_idx = 0;
  logic [DW-1:0] acc = '0;
  bit            hold_pending = 0;
  logic          hold_bit = 1'b0;
  bit            last_push = 0;
  int            n_words_out = 0;
  int            n_pushed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: words enter a queue when the handshake is seen, and every
  // accepted output bit is deserialized; each full word must equal the queue head.
  task automatic cycle();
    logic [DW-1:0] exp_w;
    @(negedge clk);
    last_push = 0;
    if (din_valid && ready_out && en) begin
      exp_q.push_back(din);
      last_push = 1;
      n_pushed++;
    end
    if (!en) begin
      check("en_low_dout_valid", {31'd0, dout_valid}, 32'd0);
      check("en_low_ready", {31'd0, ready_out}, 32'd0);
    end
    if (hold_pending && dout_valid)
      check("dout_stable", {31'd0, dout}, {31'd0, hold_bit});
    if (dout_valid && !ready_in) begin
      hold_pending = 1;
      hold_bit     = dout;
    end else if (dout_valid) begin
      hold_pending = 0;
    end
    if (dout_valid && ready_in) begin
      check("frame_start_pos", {31'd0, frame_start}, {31'd0, (bit_idx == 0)});
      acc = {acc[DW-2:0], dout};
      bit_idx++;
      if (bit_idx == DW) begin
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        check("word", {8'd0, acc}, {8'd0, exp_w});
        bit_idx = 0;
        n_words_out++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    din_valid = 1'b1;
    din       = w;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (last_push) break;
    end
    check("push_accepted", {31'd0, last_push}, 32'd1);
    din_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0 && bit_idx == 0) break;
      cycle();
    end
    check("drain_done", exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] word;
    int            accepted;
    int            base_out;
    int            vcount;
    int            target;

    // 1: reset with random inputs
    rst_n = 1'b0; en = 1'b1; din = '0; din_valid = 1'b0; ready_in = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      en        = 1'($urandom());
      din_valid = 1'($urandom());
      ready_in  = 1'($urandom());
      din       = DW'($urandom());
      #1;
      check("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
      check("rst_count", {28'd0, fifo_count}, 32'd0);
      check("rst_ready", {31'd0, ready_out}, 32'd0);
      check("rst_frame_start", {31'd0, frame_start}, 32'd0);
      cycle();
    end
    en = 1'b1; din_valid = 1'b0; ready_in = 1'b1;
    rst_n = 1'b1;
    cycle();
    check("post_rst_ready", {31'd0, ready_out}, 32'd1);
    check("post_rst_valid", {31'd0, dout_valid}, 32'd0);

    // 2: single word, latency and bit order
    word = 24'hA50F3C;
    push_word(word);
    check("lat_idle_after_push", {31'd0, dout_valid}, 32'd0);
    cycle();
    for (int i = 0; i < DW; i++) begin
      check("single_valid", {31'd0, dout_valid}, 32'd1);
      check("single_bit", {31'd0, dout}, {31'd0, word[DW-1-i]});
      check("single_frame", {31'd0, frame_start}, {31'd0, (i == 0)});
      cycle();
    end
    check("single_back_idle", {31'd0, dout_valid}, 32'd0);

    // 3: three back-to-back words with no gap
    ready_in = 1'b0;
    for (int k = 0; k < 3; k++) push_word(DW'($urandom()));
    cycle();
    ready_in = 1'b1;
    for (int i = 0; i < 3 * DW; i++) begin
      check("b2b_valid", {31'd0, dout_valid}, 32'd1);
      check("b2b_frame", {31'd0, frame_start}, {31'd0, (i % DW == 0)});
      cycle();
    end
    check("b2b_end_idle", {31'd0, dout_valid}, 32'd0);
    check("b2b_queue_empty", exp_q.size(), 32'd0);

    // 4: fill under backpressure; one word sits in the shifter, DEPTH in the FIFO
    ready_in  = 1'b0;
    accepted  = 0;
    din_valid = 1'b1;
    for (int i = 0; i < DEPTH + 4; i++) begin
      din = DW'($urandom());
      cycle();
      if (last_push) accepted++;
    end
    check("full_accepted", accepted, DEPTH + 1);
    check("full_count", {28'd0, fifo_count}, DEPTH);
    check("full_ready_low", {31'd0, ready_out}, 32'd0);
    din_valid = 1'b0;
    base_out  = n_words_out;
    ready_in  = 1'b1;
    drain();
    check("full_words_out", n_words_out - base_out, DEPTH + 1);
    cycle();
    check("full_count_zero", {28'd0, fifo_count}, 32'd0);

    // 5: random stall and enable over 100 words
    base_out = n_words_out;
    target   = n_pushed + 100;
    din      = DW'($urandom());
    for (int i = 0; i < 20000; i++) begin
      if (n_pushed >= target && exp_q.size() == 0 && bit_idx == 0) break;
      if (last_push) din = DW'($urandom());
      din_valid = (n_pushed < target) && ($urandom_range(0, 3) != 0);
      en        = ($urandom_range(0, 7) != 0);
      ready_in  = ($urandom_range(0, 2) != 0);
      cycle();
    end
    en = 1'b1; din_valid = 1'b0; ready_in = 1'b1;
    check("rand_words_out", n_words_out - base_out, 32'd100);
    check("rand_queue_empty", exp_q.size(), 32'd0);

    // 6: reset at bit 10 of a word with three more queued
    ready_in = 1'b0;
    for (int k = 0; k < 4; k++) push_word(DW'($urandom()));
    cycle();
    ready_in = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (bit_idx == 10) break;
      cycle();
    end
    check("midword_reached", bit_idx, 32'd10);
    check("midword_count", {28'd0, fifo_count}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, dout_valid}, 32'd0);
    check("midrst_dout", {31'd0, dout}, 32'd0);
    check("midrst_frame", {31'd0, frame_start}, 32'd0);
    check("midrst_count", {28'd0, fifo_count}, 32'd0);
    check("midrst_ready", {31'd0, ready_out}, 32'd0);
    exp_q.delete();
    bit_idx = 0; acc = '0; hold_pending = 0;
    cycle();
    cycle();
    rst_n  = 1'b1;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (dout_valid) vcount++;
      cycle();
    end
    check("post_midrst_silent", vcount, 32'd0);
    base_out = n_words_out;
    push_word(24'h5A5A5A);
    drain();
    check("post_midrst_word", n_words_out - base_out, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
